// File: rtl/timed_ram_if.sv
// Request/response bundle between the cache (master) and the timed backing memory (slave).
interface timed_ram_if #(
  parameter int unsigned CNT_W = 16
);
  logic             req;
  logic             wr;
  logic [31:0]      addr;
  logic [31:0]      data;
  logic             state;
  logic             done;
  logic             err;
  logic [31:0]      q;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;

  modport master (
    output req, wr, addr, data,
    input  state, done, err, q, rd_count, wr_count
  );

  modport slave (
    input  req, wr, addr, data,
    output state, done, err, q, rd_count, wr_count
  );
endinterface

// File: rtl/timed_ram.sv
// Word-addressed backing memory with fixed access latency and saturating access counters.
// Requests are latched in IDLE; the access itself happens on the BUSY->DONE edge.
module timed_ram #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  timed_ram_if.slave  io_bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               r_st;
  logic [7:0]           r_cnt;
  logic                 r_wr;
  logic [31:0]          r_addr;
  logic [31:0]          r_data;
  logic                 r_state;
  logic                 r_done;
  logic                 r_err;
  logic [31:0]          r_q;
  logic [CNT_W-1:0]     r_rd_cnt;
  logic [CNT_W-1:0]     r_wr_cnt;
  logic [31:0]          r_mem [2**ADDR_BITS];

  logic                 w_in_range;
  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_complete;
  logic                 w_mem_we;

  assign w_in_range = (r_addr >> ADDR_BITS) == 32'd0;
  assign w_idx      = r_addr[ADDR_BITS-1:0];
  assign w_complete = (r_st == StBusy) && (r_cnt == 8'd0);
  // Reset on the completion edge must suppress the write.
  assign w_mem_we   = !i_rst && w_complete && r_wr && w_in_range;

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= r_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st     <= StIdle;
      r_cnt    <= 8'd0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_state  <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_q      <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      unique case (r_st)
        StIdle: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (io_bus.req) begin
            r_wr    <= io_bus.wr;
            r_addr  <= io_bus.addr;
            r_data  <= io_bus.data;
            r_cnt   <= 8'(LATENCY - 1);
            r_st    <= StBusy;
            r_state <= 1'b0;
          end
        end
        StBusy: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_st    <= StDone;
            r_state <= 1'b1;
            r_done  <= 1'b1;
            r_err   <= !w_in_range;
            if (!r_wr) begin
              r_q <= w_in_range ? r_mem[w_idx] : 32'hDEADBEEF;
            end
            if (w_in_range && !r_wr && (r_rd_cnt != {CNT_W{1'b1}})) begin
              r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_in_range && r_wr && (r_wr_cnt != {CNT_W{1'b1}})) begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
        end
        StDone: begin
          r_st   <= StIdle;
          r_done <= 1'b0;
          r_err  <= 1'b0;
        end
        default: begin
          r_st    <= StIdle;
          r_state <= 1'b1;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.state    = r_state;
  assign io_bus.done     = r_done;
  assign io_bus.err      = r_err;
  assign io_bus.q        = r_q;
  assign io_bus.rd_count = r_rd_cnt;
  assign io_bus.wr_count = r_wr_cnt;

endmodule

// File: tb/tb_timed_ram.sv
// Directed bench for timed_ram: a vector table on the default configuration plus hand-written
// sequences for mid-access input changes, reset aborts, back-to-back requests and saturation.
module tb_timed_ram;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  timed_ram_if #(.CNT_W(16)) bus_a ();
  timed_ram_if #(.CNT_W(2))  bus_b ();

  timed_ram #(.ADDR_BITS(8), .LATENCY(4), .CNT_W(16)) dut_a (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus_a)
  );

  timed_ram #(.ADDR_BITS(8), .LATENCY(1), .CNT_W(2)) dut_b (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] q;
    int          rd;
    int          wc;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one access on bus_a from IDLE, capture results in DONE, return in IDLE.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic e, output logic [31:0] qv,
                        output int rd, output int wc);
    bus_a.req  = 1'b1;
    bus_a.wr   = w;
    bus_a.addr = a;
    bus_a.data = d;
    @(posedge clk);
    #1;
    bus_a.req = 1'b0;
    lat = 0;
    while (!bus_a.done && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e  = bus_a.err;
    qv = bus_a.q;
    rd = int'(bus_a.rd_count);
    wc = int'(bus_a.wr_count);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    logic        e;
    logic [31:0] qv;
    int          rd;
    int          wc;
    int          pulses;

    n_cmp  = 0;
    n_fail = 0;

    vecs[0] = '{1'b1, 32'h5,        32'hCAFE0001, 1'b0, 32'h0,        0, 1};
    vecs[1] = '{1'b0, 32'h5,        32'h0,        1'b0, 32'hCAFE0001, 1, 1};
    vecs[2] = '{1'b0, 32'h100,      32'h0,        1'b1, 32'hDEADBEEF, 1, 1};
    vecs[3] = '{1'b0, 32'h5,        32'h0,        1'b0, 32'hCAFE0001, 2, 1};
    vecs[4] = '{1'b1, 32'h100,      32'h123,      1'b1, 32'hCAFE0001, 2, 1};
    vecs[5] = '{1'b1, 32'h7,        32'h55,       1'b0, 32'hCAFE0001, 2, 2};
    vecs[6] = '{1'b0, 32'h7,        32'h0,        1'b0, 32'h55,       3, 2};
    vecs[7] = '{1'b1, 32'hFF,       32'h12345678, 1'b0, 32'h55,       3, 3};
    vecs[8] = '{1'b0, 32'hFF,       32'h0,        1'b0, 32'h12345678, 4, 3};
    vecs[9] = '{1'b0, 32'h80000005, 32'h0,        1'b1, 32'hDEADBEEF, 4, 3};

    rst = 1'b1;
    bus_a.req = 1'b0; bus_a.wr = 1'b0; bus_a.addr = '0; bus_a.data = '0;
    bus_b.req = 1'b0; bus_b.wr = 1'b0; bus_b.addr = '0; bus_b.data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset state", 32'(bus_a.state), 32'd1);
    check("reset done", 32'(bus_a.done), 32'd0);
    check("reset err", 32'(bus_a.err), 32'd0);
    check("reset q", bus_a.q, 32'd0);
    check("reset rd_count", 32'(bus_a.rd_count), 32'd0);
    check("reset wr_count", 32'(bus_a.wr_count), 32'd0);

    for (int i = 0; i < 10; i++) begin
      access(vecs[i].wr, vecs[i].addr, vecs[i].data, lat, e, qv, rd, wc);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].err));
      check($sformatf("vec%0d q", i), qv, vecs[i].q);
      check($sformatf("vec%0d rd_count", i), 32'(rd), 32'(vecs[i].rd));
      check($sformatf("vec%0d wr_count", i), 32'(wc), 32'(vecs[i].wc));
    end

    // Inputs changed during BUSY must not affect the latched access.
    access(1'b1, 32'h4, 32'h44, lat, e, qv, rd, wc);
    check("pre-write addr4 wr_count", 32'(wc), 32'd4);
    bus_a.req = 1'b1; bus_a.wr = 1'b1; bus_a.addr = 32'h3; bus_a.data = 32'h11;
    @(posedge clk);
    #1;
    bus_a.addr = 32'h4; bus_a.data = 32'h22; bus_a.wr = 1'b0;
    check("midchange busy state", 32'(bus_a.state), 32'd0);
    lat = 0;
    while (!bus_a.done && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    bus_a.req = 1'b0;
    check("midchange latency", 32'(lat), 32'd4);
    check("midchange err", 32'(bus_a.err), 32'd0);
    check("midchange wr_count", 32'(bus_a.wr_count), 32'd5);
    check("midchange rd_count", 32'(bus_a.rd_count), 32'd4);
    @(posedge clk);
    #1;
    access(1'b0, 32'h3, 32'h0, lat, e, qv, rd, wc);
    check("midchange mem3", qv, 32'h11);
    access(1'b0, 32'h4, 32'h0, lat, e, qv, rd, wc);
    check("midchange mem4", qv, 32'h44);

    // Reset in the 2nd BUSY cycle aborts a write of 0xAA to addr 7.
    bus_a.req = 1'b1; bus_a.wr = 1'b1; bus_a.addr = 32'h7; bus_a.data = 32'hAA;
    @(posedge clk);
    #1;
    bus_a.req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort state", 32'(bus_a.state), 32'd1);
    check("abort done", 32'(bus_a.done), 32'd0);
    check("abort q", bus_a.q, 32'd0);
    check("abort wr_count", 32'(bus_a.wr_count), 32'd0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (bus_a.done) pulses++;
    end
    check("abort done pulses", 32'(pulses), 32'd0);
    access(1'b0, 32'h7, 32'h0, lat, e, qv, rd, wc);
    check("abort mem7", qv, 32'h55);
    check("abort rd_count", 32'(rd), 32'd1);
    check("abort wr_count after", 32'(wc), 32'd0);

    // Reset coinciding with the completion edge wins.
    bus_a.req = 1'b1; bus_a.wr = 1'b1; bus_a.addr = 32'h7; bus_a.data = 32'h99;
    @(posedge clk);
    #1;
    bus_a.req = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst-wins done", 32'(bus_a.done), 32'd0);
    check("rst-wins state", 32'(bus_a.state), 32'd1);
    check("rst-wins wr_count", 32'(bus_a.wr_count), 32'd0);
    access(1'b0, 32'h7, 32'h0, lat, e, qv, rd, wc);
    check("rst-wins mem7", qv, 32'h55);

    // LATENCY=1 with req held high: one read per 3 cycles, rd_count saturates at 3.
    bus_b.req = 1'b1; bus_b.wr = 1'b0; bus_b.addr = 32'h5;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("b2b state c%0d", c), 32'(bus_b.state), (c % 3 != 0) ? 32'd1 : 32'd0);
      check($sformatf("b2b done c%0d", c), 32'(bus_b.done), (c % 3 == 1) ? 32'd1 : 32'd0);
      if (c % 3 == 1) begin
        check($sformatf("b2b rd_count c%0d", c), 32'(bus_b.rd_count),
              (c / 3 + 1 > 3) ? 32'd3 : 32'(c / 3 + 1));
      end
    end
    bus_b.req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("b2b rd_count final", 32'(bus_b.rd_count), 32'd3);
    check("b2b wr_count final", 32'(bus_b.wr_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
